// File: rtl/sig_verify_arbiter.sv
// sig_verify_arbiter
//   Shares one signature-verification pipeline between NUM_REQ requesters.
//   A round-robin arbiter accepts one request at a time. It holds the
//   signature on ver_sig for VERIFY_LATENCY cycles and captures ver_match.
//   It then returns the result to the granted requester over a
//   valid/ready response handshake.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   req_valid/req_sig     per-requester request, signature i at [32i+31:32i]
//   req_ready             one-hot accept (combinational in IDLE)
//   resp_valid/resp_match one-hot response valid and its match result
//   resp_ready            per-requester response accept
//   ver_sig/ver_match     verifier signature out, verifier result in
//   busy                  high whenever a transaction is outstanding
//   grant_cnt/match_cnt   saturating statistics counters
//
// Configuration
//   SIG_VERIFY_ARB_STATS_EN: when defined, grant_cnt/match_cnt count
//   accepts and matching responses. Otherwise they are tied to zero and no
//   counter flops exist.
module sig_verify_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int VERIFY_LATENCY = 2,
    parameter int CNT_W          = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*32-1:0]    req_sig,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       resp_valid,
    output logic                     resp_match,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [31:0]              ver_sig,
    input  logic                     ver_match,
    output logic                     busy,
    output logic [NUM_REQ*CNT_W-1:0] grant_cnt,
    output logic [CNT_W-1:0]         match_cnt
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WC_W  = $clog2(VERIFY_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] gnt_q, gnt_d;
    logic [31:0]      sig_q, sig_d;
    logic             match_q, match_d;
    logic [WC_W-1:0]  wait_q, wait_d;

    logic             found;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] idx_c;
    logic [31:0]      sig_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_sig
        assign sig_arr[g] = req_sig[g*32 +: 32];
    end

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx_c = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_c = IDX_W'((int'(last_q) + k) % NUM_REQ);
            if (!found && req_valid[idx_c]) begin
                found = 1'b1;
                win   = idx_c;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        sig_d      = sig_q;
        match_d    = match_q;
        wait_d     = wait_q;
        req_ready  = '0;
        resp_valid = '0;
        unique case (state_q)
            IDLE: begin
                // The winner is valid by construction, so ready implies handshake.
                if (found) begin
                    req_ready[win] = 1'b1;
                    sig_d          = sig_arr[win];
                    gnt_d          = win;
                    last_d         = win;
                    wait_d         = WC_W'(VERIFY_LATENCY);
                    state_d        = WAIT;
                end
            end
            WAIT: begin
                wait_d = wait_q - WC_W'(1);
                if (wait_q == WC_W'(1)) begin
                    match_d = ver_match;
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid[gnt_q] = 1'b1;
                if (resp_ready[gnt_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= IDX_W'(NUM_REQ - 1);
            gnt_q   <= '0;
            sig_q   <= '0;
            match_q <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            sig_q   <= sig_d;
            match_q <= match_d;
            wait_q  <= wait_d;
        end
    end

    // sig_q only changes on accept, so the verifier input never glitches.
    assign ver_sig    = sig_q;
    assign resp_match = match_q;
    assign busy       = (state_q != IDLE);

`ifdef SIG_VERIFY_ARB_STATS_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] gcnt_q;
    logic [CNT_W-1:0]              mcnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcnt_q <= '0;
            mcnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i] && (gcnt_q[i] != '1))
                    gcnt_q[i] <= gcnt_q[i] + CNT_W'(1);
            end
            if ((state_q == RESP) && resp_ready[gnt_q] && match_q && (mcnt_q != '1))
                mcnt_q <= mcnt_q + CNT_W'(1);
        end
    end

    assign grant_cnt = gcnt_q;
    assign match_cnt = mcnt_q;
`else
    assign grant_cnt = '0;
    assign match_cnt = '0;
`endif

endmodule

// File: doc/sig_verify_arbiter.md
# sig_verify_arbiter

Shares a single signature-verification pipeline (field-decode register stage plus pattern matcher) between `NUM_REQ` requesters. Each requester submits a 32-bit signature through a valid/ready handshake. A round-robin arbiter selects one request at a time and holds the signature stable on the verifier input for the pipeline latency. It captures the match result and returns it to the granted requester through a second valid/ready handshake. The block sits between the requester front-ends and the verifier top.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `VERIFY_LATENCY`, default 2: cycles from `ver_sig` being stable to `ver_match` being valid, ≥1.
- `CNT_W`, default 16: width of statistics counters (used only with the macro).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: request pending, one bit per requester.
- `req_sig` in NUM_REQ*32: signatures; requester i uses bits [32i+31:32i].
- `req_ready` out NUM_REQ: one-hot accept; request i is accepted on a cycle where valid[i] and ready[i] are both high.
- `resp_valid` out NUM_REQ: one-hot response valid.
- `resp_match` out 1: match result, meaningful while any `resp_valid` bit is high.
- `resp_ready` in NUM_REQ: per-requester response accept.
- `ver_sig` out 32: signature driven to the verifier.
- `ver_match` in 1: verifier match output.
- `busy` out 1: high whenever the state is not IDLE.
- `grant_cnt` out NUM_REQ*CNT_W: per-requester accepted-request count (macro only).
- `match_cnt` out CNT_W: count of responses with match=1 (macro only).

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Winner = first i with `req_valid[i]`, searching from `last_grant+1` modulo NUM_REQ.
  - `req_ready` is driven combinationally one-hot to the winner; it is all-zero when no request is valid.
  - On handshake: latch the signature into `sig_q`, latch the index into `gnt_q`, set `last_grant` to the winner, load `wait_cnt` with VERIFY_LATENCY, go to WAIT.
- WAIT:
  - `ver_sig` = `sig_q`, held constant.
  - `wait_cnt` decrements each cycle.
  - On the cycle `wait_cnt`==1: register `ver_match` into `match_q` and go to RESP.
- RESP:
  - `resp_valid[gnt_q]`=1 and `resp_match`=`match_q`, both held stable until `resp_ready[gnt_q]`=1.
  - On that edge, go to IDLE.
  - `resp_ready` bits of other requesters are ignored.
- `req_ready` is 0 in WAIT and RESP. Only one transaction is ever outstanding.
- `ver_sig` keeps the last `sig_q` in IDLE and RESP, so the verifier input never glitches.
- A requester dropping `req_valid` without a handshake is never granted and leaves no state behind.
- A `resp_ready` while `resp_valid` is low has no effect.

## Timing
- Reset values: state=IDLE, `last_grant`=NUM_REQ-1 (requester 0 wins first), `sig_q`=0, `gnt_q`=0, `match_q`=0.
- Reset values of outputs: `req_ready`=0 except the combinational IDLE grant, `resp_valid`=0, `resp_match`=0, `ver_sig`=0, `busy`=0, counters=0.
- Request handshake at edge T:
  - `ver_sig` updates at T+1.
  - `ver_match` is captured at edge T+VERIFY_LATENCY.
  - `resp_valid` goes high in cycle T+VERIFY_LATENCY+1.
- Response handshake at edge R: IDLE in cycle R+1, where a new grant can be made in the same cycle.
- Minimum spacing between accepts: VERIFY_LATENCY+2 cycles.
- Round-robin fairness: with all requesters continuously valid, grants follow 0,1,2,…,NUM_REQ-1,0.
- `last_grant` updates only on an accepted handshake.
- Reset asserted mid-transaction: the transaction is abandoned and no response is issued. Requesters re-submit after reset.

## Configuration
- `SIG_VERIFY_ARB_STATS_EN` defined:
  - `grant_cnt[i]` increments on each accepted request from requester i.
  - `match_cnt` increments on each completed response handshake with `resp_match`=1.
  - Both counters saturate at 2^CNT_W-1 and are cleared only by reset.
- Not defined: `grant_cnt` and `match_cnt` are tied to 0 and no counter flops are generated. The ports remain for a stable interface.

## Test plan
1. Single request, no contention (NUM_REQ=4, VERIFY_LATENCY=2): requester 2 submits 32'hA1B2C3D4 with `ver_match` forced 1 → `req_ready`=4'b0100 in the same cycle, `ver_sig`=32'hA1B2C3D4 the next cycle, `resp_valid`=4'b0100 with `resp_match`=1 exactly 3 cycles after accept.
2. All four requesters held valid for 8 transactions, `resp_ready` tied high → grant order 0,1,2,3,0,1,2,3; accepts spaced exactly 4 cycles apart.
3. Back-pressure: `resp_ready[1]`=0 for 10 cycles with requester 3 valid → `resp_valid[1]` and `resp_match` stable for all 10 cycles; `req_ready`=0 throughout; requester 3 is granted the cycle after `resp_ready[1]` rises.
4. Reset mid-operation: pull `rst_n` low during WAIT → `busy`, `resp_valid` and `ver_sig` go to 0 immediately; after release, requester 0 wins over requester 3 when both are valid.
5. Macro defined, CNT_W=4: 20 accepts from requester 0, all matching → `grant_cnt[0]`=15 (saturated), `match_cnt`=15, other `grant_cnt` bits 0.
6. Macro undefined, same stimulus as test 5 → `grant_cnt`=0 and `match_cnt`=0 throughout.
